// File: rtl/sw_input_ctrl.sv
// sw_input_ctrl: read-only bus peripheral for the 24 board switches.
// The raw levels pass through a two-stage synchronizer and a whole-vector
// debouncer. Bits that changed are latched into a sticky change register
// and raise a level interrupt. The CPU reads state through a registered
// four-word window.
module sw_input_ctrl #(
  parameter logic [31:0] BASE_ADDR       = 32'hFFFF_F070,
  parameter int          DEBOUNCE_CYCLES = 20000,
  parameter int          CNT_W           = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] device_sw,
  input  logic [31:0] addr,
  input  logic        rd_en,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [23:0]      sync1;
  logic [23:0]      sync2;
  logic [23:0]      cand;
  logic [23:0]      stable;
  logic [23:0]      chg;
  logic [23:0]      chg_next;
  logic [23:0]      new_chg;
  logic [CNT_W-1:0] cnt;
  logic             sel;
  logic             load;
  logic             chg_rd;
  logic [1:0]       reg_idx;
  logic [31:0]      rd_mux;

  // Accesses are word-wide, so the byte-lane bits carry no information.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  // Two-flop synchronizer for the asynchronous switch levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= device_sw;
      sync2 <= sync1;
    end
  end

  // Shared debounce counter: any bit moving restarts the whole vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else if (sync2 != cand) begin
      cand <= sync2;
      cnt  <= '0;
    end else if (cnt == CNT_TC) begin
      stable <= cand;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Decode, change-capture merge and read mux. A fresh change that lands
  // on the same cycle as a CHG read-clear survives the clear.
  always_comb begin
    sel      = rd_en && (addr[31:4] == BASE_ADDR[31:4]);
    reg_idx  = addr[3:2];
    load     = (sync2 == cand) && (cnt == CNT_TC);
    new_chg  = load ? (stable ^ cand) : '0;
    chg_rd   = sel && (reg_idx == 2'd1);
    chg_next = chg_rd ? new_chg : (chg | new_chg);
    rd_mux   = '0;
    case (reg_idx)
      2'd0:    rd_mux = {8'h0, stable};
      2'd1:    rd_mux = {8'h0, chg};
      2'd2:    rd_mux = {30'h0, |chg, |stable};
      default: rd_mux = '0;
    endcase
  end

  // Sticky change bits and the interrupt derived from their next value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg <= '0;
      irq <= 1'b0;
    end else begin
      chg <= chg_next;
      irq <= |chg_next;
    end
  end

  // Registered read response; rdata is held at zero outside a valid beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= sel;
      rdata  <= sel ? rd_mux : '0;
    end
  end

endmodule
